// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_pkg
// Purpose  : Shared definitions for the GCD Euclid sequencer: FSM state
//            encoding, default operand width and error-cause codes.
// Revision : 1.0 - initial release
// ============================================================================
package gcd_pkg;

    // Default operand/result width
    localparam int c_default_width = 16;

    // FSM state encoding
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_check = 3'd1;
    localparam logic [2:0] c_st_start = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = c_st_idle,
        S_CHECK = c_st_check,
        S_START = c_st_start,
        S_WAIT  = c_st_wait,
        S_DONE  = c_st_done
    } state_t;

    // Error causes; err_o is asserted for any cause other than c_err_none
    localparam logic [2:0] c_err_none  = 3'd0;  // valid GCD
    localparam logic [2:0] c_err_zero  = 3'd1;  // gcd(0,0) is undefined
    localparam logic [2:0] c_err_iter  = 3'd2;  // round budget exhausted
    localparam logic [2:0] c_err_proto = 3'd3;  // modulo unit returned rem >= divisor
`ifdef GCD_MOD_TIMEOUT_EN
    localparam logic [2:0] c_err_tmo   = 3'd4;  // modulo unit never answered
`endif

endpackage : gcd_pkg
`default_nettype wire

// File: rtl/gcd_operand_regs.sv
`default_nettype none
// ============================================================================
// Module   : gcd_operand_regs
// Purpose  : Operand register file for the Euclid sequencer. Holds the
//            current dividend (a), divisor (b) and round counter (iter).
// Ports    : clk, rst_i (async, active-low)
//            i_clear  - zero a, b and iter (highest priority)
//            i_load   - a <= i_load_a, b <= i_load_b, iter <= 0
//            i_rotate - a <= b, b <= i_rem, iter <= iter + 1 (saturating)
//            o_a, o_b, o_iter - register contents
// Revision : 1.0 - initial release
// ============================================================================
module gcd_operand_regs #(
    parameter int WIDTH    = 16,
    parameter int MAX_ITER = 32,
    parameter int ITER_W   = 6
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_rotate,
    input  logic [WIDTH-1:0]  i_load_a,
    input  logic [WIDTH-1:0]  i_load_b,
    input  logic [WIDTH-1:0]  i_rem,
    output logic [WIDTH-1:0]  o_a,
    output logic [WIDTH-1:0]  o_b,
    output logic [ITER_W-1:0] o_iter
);

    localparam logic [ITER_W-1:0] c_iter_max = ITER_W'(MAX_ITER);

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [ITER_W-1:0] r_iter;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_a    <= '0;
            r_b    <= '0;
            r_iter <= '0;
        end else if (i_clear) begin
            r_a    <= '0;
            r_b    <= '0;
            r_iter <= '0;
        end else if (i_load) begin
            r_a    <= i_load_a;
            r_b    <= i_load_b;
            r_iter <= '0;
        end else if (i_rotate) begin
            r_a <= r_b;
            r_b <= i_rem;
            // Saturate rather than wrap so the round-limit check cannot be skipped
            if (r_iter != c_iter_max) begin
                r_iter <= r_iter + 1'b1;
            end
        end
    end

    assign o_a    = r_a;
    assign o_b    = r_b;
    assign o_iter = r_iter;

endmodule : gcd_operand_regs
`default_nettype wire

// File: rtl/gcd_euclid_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gcd_euclid_sequencer
// Purpose  : Drives an external modulo unit round by round (a mod b), rotating
//            the operands after each remainder until it is zero, then presents
//            the GCD on a valid/ready output.
// Config   : GCD_MOD_TIMEOUT_EN - when defined, a watchdog aborts a WAIT that
//            lasts TIMEOUT_CYC cycles with gcd=0, err=1.
// Ports    : clk, rst_i (async, active-low)
//            in_valid_i/in_ready_o, zahl1_i, zahl2_i  - operand pair input
//            mod_start_o, mod_dividend_o, mod_divisor_o - modulo request
//            mod_valid_i, mod_rem_i                    - modulo response
//            out_valid_o/out_ready_i, gcd_o, err_o, iter_o - result output
// Revision : 1.0 - initial release
// ============================================================================
module gcd_euclid_sequencer
    import gcd_pkg::*;
#(
    parameter int  WIDTH       = c_default_width,
    parameter int  MAX_ITER    = 32,
    parameter int  TIMEOUT_CYC = 255,
    localparam int c_iter_w    = $clog2(MAX_ITER + 1)
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [WIDTH-1:0]    zahl1_i,
    input  logic [WIDTH-1:0]    zahl2_i,
    output logic                mod_start_o,
    output logic [WIDTH-1:0]    mod_dividend_o,
    output logic [WIDTH-1:0]    mod_divisor_o,
    input  logic                mod_valid_i,
    input  logic [WIDTH-1:0]    mod_rem_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [WIDTH-1:0]    gcd_o,
    output logic                err_o,
    output logic [c_iter_w-1:0] iter_o
);

    localparam logic [c_iter_w-1:0] c_iter_max = c_iter_w'(MAX_ITER);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [WIDTH-1:0]    w_a;
    logic [WIDTH-1:0]    w_b;
    logic [c_iter_w-1:0] w_iter;

    logic                w_load;
    logic                w_rotate;
    logic                w_clear;
    logic                w_set_res;
    logic [WIDTH-1:0]    w_gcd_nxt;
    logic [2:0]          w_cause_nxt;
    logic                w_wdog_expire;

    logic [WIDTH-1:0]    r_gcd;
    logic [2:0]          r_cause;

    gcd_operand_regs #(
        .WIDTH    (WIDTH),
        .MAX_ITER (MAX_ITER),
        .ITER_W   (c_iter_w)
    ) u_operand_regs (
        .clk      (clk),
        .rst_i    (rst_i),
        .i_clear  (w_clear),
        .i_load   (w_load),
        .i_rotate (w_rotate),
        .i_load_a (zahl1_i),
        .i_load_b (zahl2_i),
        .i_rem    (mod_rem_i),
        .o_a      (w_a),
        .o_b      (w_b),
        .o_iter   (w_iter)
    );

`ifdef GCD_MOD_TIMEOUT_EN
    // Watchdog: zeroed while issuing the start pulse, counts each WAIT cycle.
    // Expiry is flagged in the WAIT cycle that completes TIMEOUT_CYC cycles.
    localparam int c_wdog_raw = $clog2(TIMEOUT_CYC + 1);
    localparam int c_wdog_w   = (c_wdog_raw > 8) ? c_wdog_raw : 8;
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT_CYC - 1);

    logic [c_wdog_w-1:0] r_wdog;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_wdog <= '0;
        end else if (r_state == S_START) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_wdog_expire = (r_state == S_WAIT) && (r_wdog == c_wdog_last);
`else
    // No watchdog in this build; the parameter is kept so both builds share
    // one instantiation interface.
    localparam int c_timeout_unused = TIMEOUT_CYC;
    assign w_wdog_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_rotate    = 1'b0;
        w_clear     = 1'b0;
        w_set_res   = 1'b0;
        w_gcd_nxt   = '0;
        w_cause_nxt = c_err_none;

        case (r_state)
            S_IDLE: begin
                if (in_valid_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end

            S_CHECK: begin
                if (w_b == '0) begin
                    w_set_res   = 1'b1;
                    w_gcd_nxt   = w_a;
                    w_cause_nxt = (w_a == '0) ? c_err_zero : c_err_none;
                    w_state_nxt = S_DONE;
                end else if (w_iter == c_iter_max) begin
                    w_set_res   = 1'b1;
                    w_cause_nxt = c_err_iter;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                // A response in the expiry cycle still wins over the watchdog
                if (mod_valid_i) begin
                    if (mod_rem_i >= w_b) begin
                        w_set_res   = 1'b1;
                        w_cause_nxt = c_err_proto;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_rotate    = 1'b1;
                        w_state_nxt = S_CHECK;
                    end
                end else if (w_wdog_expire) begin
                    w_set_res   = 1'b1;
`ifdef GCD_MOD_TIMEOUT_EN
                    w_cause_nxt = c_err_tmo;
`else
                    w_cause_nxt = c_err_proto;
`endif
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready_i) begin
                    // Scrub the operand file once the result has been taken
                    w_clear     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Result registers, written once per operand pair on the way into DONE
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_gcd   <= '0;
            r_cause <= c_err_none;
        end else if (w_set_res) begin
            r_gcd   <= w_gcd_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    // Moore outputs
    assign in_ready_o     = (r_state == S_IDLE);
    assign mod_start_o    = (r_state == S_START);
    assign mod_dividend_o = ((r_state == S_START) || (r_state == S_WAIT)) ? w_a : '0;
    assign mod_divisor_o  = ((r_state == S_START) || (r_state == S_WAIT)) ? w_b : '0;
    assign out_valid_o    = (r_state == S_DONE);
    assign gcd_o          = r_gcd;
    assign err_o          = (r_cause != c_err_none);
    assign iter_o         = w_iter;

endmodule : gcd_euclid_sequencer
`default_nettype wire
